// File: rtl/pipe_pkg.sv
// pipe_pkg: shared encodings for the front-end pipeline
package pipe_pkg;
  localparam logic [31:0] NOOP_INSN = 32'b0;
  typedef struct packed {
    logic [4:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [11:0] imm;
  } insn_t;
  typedef enum logic [1:0] {RUN = 2'd0, LW_BUBBLE = 2'd1, MD_WAIT = 2'd2} state_t;
endpackage

// File: rtl/pipe_latch.sv
// pipe_latch: pc+insn pipeline register with hold and clear-to-noop
module pipe_latch import pipe_pkg::*; #(
  parameter int PC_W = 12,
  parameter int INSN_W = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              en,
  input  logic              clr,
  input  logic [PC_W-1:0]   pc_in,
  input  logic [INSN_W-1:0] insn_in,
  output logic [PC_W-1:0]   pc,
  output logic [INSN_W-1:0] insn
);
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      pc <= '0;
      insn <= INSN_W'(NOOP_INSN);
    end else if (en) begin
      pc <= pc_in;
      insn <= clr ? INSN_W'(NOOP_INSN) : insn_in;
    end
endmodule

// File: rtl/fd_dx_pipe_ctrl.sv
// fd_dx_pipe_ctrl: pc, F/D and D/X control with load-use bubble, multdiv freeze and branch flush
module fd_dx_pipe_ctrl import pipe_pkg::*; #(
  parameter int PC_W = 12,
  parameter int INSN_W = 32,
  parameter int CNT_W = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [INSN_W-1:0] imem_insn,
  input  logic              stall_lw,
  input  logic              md_busy,
  input  logic              branch_taken,
  input  logic [PC_W-1:0]   branch_target,
  output logic [PC_W-1:0]   pc_out,
  output logic [PC_W-1:0]   fd_pc,
  output logic [INSN_W-1:0] fd_insn,
  output logic              fd_is_noop,
  output logic [PC_W-1:0]   dx_pc,
  output logic [INSN_W-1:0] dx_insn,
  output logic [CNT_W-1:0]  stall_cnt
);
  state_t state, state_nx;
  logic freeze, bubble, pc_en, dx_en, dx_clr, cnt_inc;
  logic [PC_W-1:0] pc_nx;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state <= RUN;
    else state <= state_nx;
  always_comb
    state_nx = branch_taken ? RUN :
               md_busy ? MD_WAIT :
               (stall_lw && state == RUN) ? LW_BUBBLE : RUN;
  always_comb begin
    freeze = !branch_taken && md_busy;
    bubble = !branch_taken && !md_busy && stall_lw && state == RUN;
    pc_en = !freeze && !bubble;
    dx_en = !freeze;
    dx_clr = branch_taken || bubble;
    cnt_inc = freeze || bubble;
    pc_nx = branch_taken ? branch_target : pc_out + PC_W'(1);
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      pc_out <= '0;
      stall_cnt <= '0;
    end else begin
      if (pc_en) pc_out <= pc_nx;
      if (cnt_inc && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  pipe_latch #(.PC_W(PC_W), .INSN_W(INSN_W)) u_fd (
    .clock(clock), .reset_n(reset_n), .en(pc_en), .clr(branch_taken),
    .pc_in(pc_out), .insn_in(imem_insn), .pc(fd_pc), .insn(fd_insn)
  );
  pipe_latch #(.PC_W(PC_W), .INSN_W(INSN_W)) u_dx (
    .clock(clock), .reset_n(reset_n), .en(dx_en), .clr(dx_clr),
    .pc_in(fd_pc), .insn_in(fd_insn), .pc(dx_pc), .insn(dx_insn)
  );
  assign fd_is_noop = fd_insn == INSN_W'(NOOP_INSN);
endmodule

// File: tb/tb_fd_dx_pipe_ctrl.sv
// tb_fd_dx_pipe_ctrl: scoreboard bench against a behavioural pipeline model
module tb_fd_dx_pipe_ctrl;
  localparam int PC_W = 12;
  localparam int INSN_W = 32;
  localparam int CNT_W = 5;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic [INSN_W-1:0] imem_insn;
  logic stall_lw = 1'b0;
  logic md_busy = 1'b0;
  logic branch_taken = 1'b0;
  logic [PC_W-1:0] branch_target = '0;
  logic [PC_W-1:0] pc_out, fd_pc, dx_pc;
  logic [INSN_W-1:0] fd_insn, dx_insn;
  logic fd_is_noop;
  logic [CNT_W-1:0] stall_cnt;
  logic [INSN_W-1:0] mem [0:(1<<PC_W)-1];
  typedef struct {
    logic [PC_W-1:0] pc, fd_pc, dx_pc;
    logic [INSN_W-1:0] fd_insn, dx_insn;
    logic [CNT_W-1:0] cnt;
  } exp_t;
  exp_t sb[$];
  exp_t m, mon_e;
  int last_kind = 0;
  int tests = 0;
  int fails = 0;
  fd_dx_pipe_ctrl #(.PC_W(PC_W), .INSN_W(INSN_W), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset_n(reset_n), .imem_insn(imem_insn), .stall_lw(stall_lw),
    .md_busy(md_busy), .branch_taken(branch_taken), .branch_target(branch_target),
    .pc_out(pc_out), .fd_pc(fd_pc), .fd_insn(fd_insn), .fd_is_noop(fd_is_noop),
    .dx_pc(dx_pc), .dx_insn(dx_insn), .stall_cnt(stall_cnt)
  );
  assign imem_insn = mem[pc_out];
  always #5 clock = ~clock;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic cmp(exp_t e);
    chk("pc_out", 32'(pc_out), 32'(e.pc));
    chk("fd_pc", 32'(fd_pc), 32'(e.fd_pc));
    chk("fd_insn", fd_insn, e.fd_insn);
    chk("fd_is_noop", 32'(fd_is_noop), 32'(e.fd_insn == 0));
    chk("dx_pc", 32'(dx_pc), 32'(e.dx_pc));
    chk("dx_insn", dx_insn, e.dx_insn);
    chk("stall_cnt", 32'(stall_cnt), 32'(e.cnt));
  endtask
  task automatic model_reset();
    m.pc = '0; m.fd_pc = '0; m.dx_pc = '0;
    m.fd_insn = '0; m.dx_insn = '0; m.cnt = '0;
    last_kind = 0;
  endtask
  task automatic count_stall();
    if (m.cnt != {CNT_W{1'b1}}) m.cnt = m.cnt + 1'b1;
  endtask
  task automatic step(bit br, logic [PC_W-1:0] tgt, bit lw, bit md);
    @(negedge clock);
    branch_taken = br;
    branch_target = tgt;
    stall_lw = lw;
    md_busy = md;
    if (br) begin
      m.dx_pc = m.fd_pc; m.fd_pc = m.pc; m.pc = tgt;
      m.fd_insn = '0; m.dx_insn = '0;
      last_kind = 0;
    end else if (md) begin
      count_stall();
      last_kind = 2;
    end else if (lw && last_kind == 0) begin
      m.dx_pc = m.fd_pc; m.dx_insn = '0;
      count_stall();
      last_kind = 1;
    end else begin
      m.dx_pc = m.fd_pc; m.dx_insn = m.fd_insn;
      m.fd_pc = m.pc; m.fd_insn = mem[m.pc];
      m.pc = m.pc + 1'b1;
      last_kind = 0;
    end
    sb.push_back(m);
  endtask
  always @(posedge clock) begin
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      cmp(mon_e);
    end
  end
  initial begin
    for (int i = 0; i < (1 << PC_W); i++)
      mem[i] = i < 16 ? INSN_W'(i + 'h100) : ($urandom_range(0, 7) == 0 ? '0 : $urandom);
    model_reset();
    #1;
    cmp(m);
    @(posedge clock);
    #3 reset_n = 1'b1;
    repeat (5) step(0, '0, 0, 0);
    step(0, '0, 1, 0);
    step(0, '0, 0, 0);
    repeat (3) step(0, '0, 1, 0);
    step(0, '0, 0, 0);
    repeat (4) step(0, '0, 0, 1);
    step(0, '0, 0, 0);
    step(1, 12'h020, 1, 0);
    step(0, '0, 0, 0);
    step(1, 12'hfff, 0, 0);
    repeat (3) step(0, '0, 0, 0);
    step(1, 12'h100, 0, 1);
    repeat (3) step(0, '0, 0, 1);
    @(posedge clock);
    #3 reset_n = 1'b0;
    stall_lw = 1'b0; md_busy = 1'b0; branch_taken = 1'b0;
    model_reset();
    #1;
    cmp(m);
    @(posedge clock);
    #3 reset_n = 1'b1;
    repeat (3) step(0, '0, 0, 0);
    repeat (400)
      step($urandom_range(0, 9) == 0, PC_W'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0);
    repeat (3) @(posedge clock);
    #2;
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
